gpio_regbank: RTL and testbench

//  Parametrised GPIO register bank for the RISC-V microcontroller peripheral bus; successor to the fixed 16-pin GPIO register file.

---
 rtl/gpio_regbank.sv | 146 ++++++++++++++
 tb/tb_gpio_regbank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gpio_regbank.sv
// GPIO register bank: bus registers, pad synchronisers, edge-detect interrupts; GPIO_ATOMIC_EN adds DATA_SET/DATA_CLR.
// Latency: rdata/rdata_valid 1 clk after read; pad->PINSTATE SYNC_STAGES clks; pin_sync edge->gpio_irq 2 clks.
// Backpressure: none, every bus access completes in one cycle and is never stalled.
module gpio_regbank #(
    parameter int          NUM_PINS     = 16,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] CHIP_NAME    = 32'h48524a44,
    parameter logic [31:0] CHIP_VERSION = 32'h00000002
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sel,
    input  logic [3:0]          addr,
    input  logic [3:0]          wben,
    input  logic                r_wn,
    input  logic [31:0]         wdata,
    input  logic [NUM_PINS-1:0] ro_gpio_pinstate,
    output logic [31:0]         rdata,
    output logic                rdata_valid,
    output logic [NUM_PINS-1:0] rf_gpio_datareg,
    output logic [NUM_PINS-1:0] rf_gpio_tristate,
    output logic                gpio_irq
);
    localparam int NP = NUM_PINS;

    localparam logic [3:0] A_CNAME    = 4'd0;
    localparam logic [3:0] A_CVERSION = 4'd1;
    localparam logic [3:0] A_TRISTATE = 4'd2;
    localparam logic [3:0] A_PINSTATE = 4'd3;
    localparam logic [3:0] A_IRQ_MASK = 4'd4;
    localparam logic [3:0] A_DATAREG  = 4'd5;
    localparam logic [3:0] A_SCRATCH  = 4'd6;
    localparam logic [3:0] A_IRQ_STAT = 4'd7;
    localparam logic [3:0] A_RISE_EN  = 4'd8;
    localparam logic [3:0] A_FALL_EN  = 4'd9;
`ifdef GPIO_ATOMIC_EN
    localparam logic [3:0] A_DATA_SET = 4'd10;
    localparam logic [3:0] A_DATA_CLR = 4'd11;
`endif

    logic [NP-1:0] tristate_q, datareg_q, mask_q, status_q, rise_en_q, fall_en_q;
    logic [31:0]   scratch_q;
    logic [NP-1:0] sync_q [SYNC_STAGES];
    logic [NP-1:0] pin_prev_q;
    logic [NP-1:0] pin_sync;
    logic [NP-1:0] edge_det;
    logic [NP-1:0] w1c;
    logic [NP-1:0] be_np;
    logic [NP-1:0] wd_np;
    logic [31:0]   be_mask;
    logic [31:0]   rd_val;
    logic          wr_en;
    logic          rd_en;

    assign wr_en = sel & ~r_wn;
    assign rd_en = sel & r_wn;

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < 4; k++) begin
            be_mask[8*k +: 8] = {8{wben[k]}};
        end
    end

    // Narrowing to NP bits is what makes bits >= NUM_PINS ignore writes and read 0.
    assign be_np    = be_mask[NP-1:0];
    assign wd_np    = wdata[NP-1:0] & be_np;
    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign edge_det = (pin_sync & ~pin_prev_q & rise_en_q) | (~pin_sync & pin_prev_q & fall_en_q);
    assign w1c      = (wr_en && addr == A_IRQ_STAT) ? wd_np : '0;

    function automatic logic [NP-1:0] merge(input logic [NP-1:0] old,
                                            input logic [NP-1:0] be,
                                            input logic [NP-1:0] wd);
        return (old & ~be) | wd;
    endfunction

    always_comb begin
        rd_val = '0;
        unique case (addr)
            A_CNAME:    rd_val = CHIP_NAME;
            A_CVERSION: rd_val = CHIP_VERSION;
            A_TRISTATE: rd_val = 32'(tristate_q);
            A_PINSTATE: rd_val = 32'(pin_sync);
            A_IRQ_MASK: rd_val = 32'(mask_q);
            A_DATAREG:  rd_val = 32'(datareg_q);
            A_SCRATCH:  rd_val = scratch_q;
            A_IRQ_STAT: rd_val = 32'(status_q);
            A_RISE_EN:  rd_val = 32'(rise_en_q);
            A_FALL_EN:  rd_val = 32'(fall_en_q);
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            pin_prev_q  <= '0;
            tristate_q  <= '0;
            datareg_q   <= '0;
            mask_q      <= '0;
            status_q    <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            scratch_q   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            gpio_irq    <= 1'b0;
        end else begin
            sync_q[0] <= ro_gpio_pinstate;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            pin_prev_q <= pin_sync;
            // Clear first, then OR in new edges so a same-cycle edge beats the W1C.
            status_q   <= (status_q & ~w1c) | edge_det;
            gpio_irq   <= |(status_q & mask_q);

            rdata_valid <= rd_en;
            if (rd_en) begin
                rdata <= rd_val;
            end

            if (wr_en) begin
                unique case (addr)
                    A_TRISTATE: tristate_q <= merge(tristate_q, be_np, wd_np);
                    A_IRQ_MASK: mask_q     <= merge(mask_q, be_np, wd_np);
                    A_DATAREG:  datareg_q  <= merge(datareg_q, be_np, wd_np);
                    A_SCRATCH:  scratch_q  <= (scratch_q & ~be_mask) | (wdata & be_mask);
                    A_RISE_EN:  rise_en_q  <= merge(rise_en_q, be_np, wd_np);
                    A_FALL_EN:  fall_en_q  <= merge(fall_en_q, be_np, wd_np);
`ifdef GPIO_ATOMIC_EN
                    A_DATA_SET: datareg_q  <= datareg_q | wd_np;
                    A_DATA_CLR: datareg_q  <= datareg_q & ~wd_np;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign rf_gpio_datareg  = datareg_q;
    assign rf_gpio_tristate = tristate_q;
endmodule

// File: tb/tb_gpio_regbank.sv
// Directed bench for gpio_regbank (NUM_PINS=16, SYNC_STAGES=2); expectations follow GPIO_ATOMIC_EN if defined.
module tb_gpio_regbank;
    localparam int NP = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sel = 1'b0;
    logic [3:0]    addr = '0;
    logic [3:0]    wben = '0;
    logic          r_wn = 1'b0;
    logic [31:0]   wdata = '0;
    logic [NP-1:0] ro_gpio_pinstate = '0;
    logic [31:0]   rdata;
    logic          rdata_valid;
    logic [NP-1:0] rf_gpio_datareg;
    logic [NP-1:0] rf_gpio_tristate;
    logic          gpio_irq;

    int n_vec = 0;
    int n_err = 0;

    gpio_regbank #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .addr(addr), .wben(wben), .r_wn(r_wn),
        .wdata(wdata), .ro_gpio_pinstate(ro_gpio_pinstate), .rdata(rdata),
        .rdata_valid(rdata_valid), .rf_gpio_datareg(rf_gpio_datareg),
        .rf_gpio_tristate(rf_gpio_tristate), .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        sel = 1'b1; r_wn = 1'b0; addr = a; wben = be; wdata = d;
        tick();
        sel = 1'b0; wben = '0;
    endtask

    task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        sel = 1'b1; r_wn = 1'b1; addr = a;
        tick();
        sel = 1'b0; r_wn = 1'b0;
        check_vec({tag, "_valid"}, 32'(rdata_valid), 32'd1);
        check_vec(tag, rdata, exp);
    endtask

    logic [31:0] exp_set;
    logic [31:0] exp_clr;

    initial begin
`ifdef GPIO_ATOMIC_EN
        exp_set = 32'h000000FF;
        exp_clr = 32'h0000007E;
`else
        exp_set = 32'h000000F0;
        exp_clr = 32'h000000F0;
`endif
        repeat (3) tick();
        check_vec("rst_rdata", rdata, 32'h0);
        check_vec("rst_valid", 32'(rdata_valid), 32'h0);
        check_vec("rst_tristate", 32'(rf_gpio_tristate), 32'h0);
        check_vec("rst_datareg", 32'(rf_gpio_datareg), 32'h0);
        check_vec("rst_irq", 32'(gpio_irq), 32'h0);
        reset_n = 1'b1;
        tick();

        bus_read("cname", 4'd0, 32'h48524a44);
        tick();
        check_vec("valid_pulse", 32'(rdata_valid), 32'h0);
        check_vec("rdata_hold", rdata, 32'h48524a44);
        bus_read("cversion", 4'd1, 32'h00000002);

        bus_write(4'd2, 4'b0001, 32'hFFFFFFFF);
        check_vec("tristate_out", 32'(rf_gpio_tristate), 32'h000000FF);
        bus_read("tristate_rd", 4'd2, 32'h000000FF);

        bus_write(4'd6, 4'b1010, 32'h12345678);
        bus_read("scratch_be", 4'd6, 32'h12005600);
        bus_write(4'd5, 4'b1111, 32'hFFFFFFFF);
        bus_read("datareg_width", 4'd5, 32'h0000FFFF);
        bus_write(4'd12, 4'b1111, 32'hFFFFFFFF);
        bus_read("reserved", 4'd12, 32'h0);

        // Rising edge on pad 0: status at SS+1 clocks, irq one clock later.
        bus_write(4'd8, 4'b0001, 32'h1);
        bus_write(4'd4, 4'b0001, 32'h1);
        ro_gpio_pinstate[0] = 1'b1;
        repeat (SS + 1) tick();
        check_vec("irq_early", 32'(gpio_irq), 32'h0);
        tick();
        check_vec("irq_rise", 32'(gpio_irq), 32'h1);
        bus_read("status_rise", 4'd7, 32'h1);
        bus_read("pinstate", 4'd3, 32'h1);

        bus_write(4'd7, 4'b0001, 32'h1);
        tick();
        check_vec("irq_w1c", 32'(gpio_irq), 32'h0);
        bus_read("status_w1c", 4'd7, 32'h0);

        // Fall edge detected in the same cycle the W1C is sampled: set wins.
        bus_write(4'd9, 4'b0001, 32'h1);
        ro_gpio_pinstate[0] = 1'b0;
        repeat (SS) tick();
        bus_write(4'd7, 4'b0001, 32'h1);
        bus_read("status_setwins", 4'd7, 32'h1);
        check_vec("irq_fall", 32'(gpio_irq), 32'h1);

        bus_write(4'd4, 4'b0001, 32'h0);
        tick();
        check_vec("irq_masked", 32'(gpio_irq), 32'h0);
        bus_read("status_kept", 4'd7, 32'h1);
        bus_write(4'd7, 4'b0001, 32'h1);

        bus_write(4'd5, 4'b0011, 32'h000000F0);
        bus_write(4'd10, 4'b0011, 32'h0000000F);
        check_vec("data_set", 32'(rf_gpio_datareg), exp_set);
        bus_write(4'd11, 4'b0011, 32'h00000081);
        check_vec("data_clr", 32'(rf_gpio_datareg), exp_clr);
        bus_read("set_reads0", 4'd10, 32'h0);

        // Reset asserted during a read cycle.
        sel = 1'b1; r_wn = 1'b1; addr = 4'd0; reset_n = 1'b0;
        tick();
        sel = 1'b0; r_wn = 1'b0;
        check_vec("rstrd_rdata", rdata, 32'h0);
        check_vec("rstrd_valid", 32'(rdata_valid), 32'h0);
        check_vec("rstrd_tristate", 32'(rf_gpio_tristate), 32'h0);
        check_vec("rstrd_datareg", 32'(rf_gpio_datareg), 32'h0);
        check_vec("rstrd_irq", 32'(gpio_irq), 32'h0);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
